pc_fetch_stage: RTL and testbench
=================================

// Module: pc_fetch_stage
// PURPOSE
//  - Fetch stage that consumes the 64-bit next-PC produced by the 2:1 next-PC mux (PC+4 vs branch target).
//  - Holds the program counter and drives the instruction-memory address.
//  - Returns PC+4 to the mux input and registers {PC, instruction, valid} into the IF/ID pipeline register.
//  - Handles load-use stall, branch flush and a one-cycle boot bubble after reset.
// PARAMETERS
//  - ADDR_W    64                     PC / address width
//  - INST_W    32                     instruction width
//  - RESET_PC  64'h0                  PC value loaded on reset
//  - NOP_INST  32'hD503201F           ARMv8 NOP inserted into IF/ID on bubble or flush
// PORTS
//  - clk          in   1       single clock; all state updates on rising edge
//  - reset        in   1       synchronous, active-high
//  - NextPC       in   ADDR_W  next-PC mux output
//  - Stall        in   1       hazard unit: hold PC and IF/ID
//  - Flush        in   1       branch taken: squash IF/ID
//  - InstIn       in   INST_W  instruction memory read data for the address on PC (combinational read)
//  - PC           out  ADDR_W  current PC; also the instruction memory address
//  - PCPlus4      out  ADDR_W  PC + 4, combinational, feeds the mux input A
//  - IFID_PC      out  ADDR_W  registered PC of the fetched instruction
//  - IFID_Inst    out  INST_W  registered instruction
//  - IFID_Valid   out  1       1 = IF/ID holds a real instruction
//  - Misaligned   out  1       registered; NextPC[1:0] != 0 was accepted
// BEHAVIOUR
//  - Reset (sync, high): PC=RESET_PC, IFID_PC=0, IFID_Inst=NOP_INST, IFID_Valid=0, Misaligned=0, FSM=BOOT.
//  - Reset overrides every other input. Asserting reset mid-stall or mid-flush restores all reset values on the next edge.
//  - FSM has 2 states:
//      BOOT: first edge after reset is released -> IF/ID captures a bubble (Valid=0, Inst=NOP). PC still advances unless Stall=1. Next state RUN.
//      RUN: stays in RUN until reset.
//  - PC register:
//      Stall=0 -> PC <= {NextPC[ADDR_W-1:2], 2'b00}.
//      Stall=1 -> PC holds.
//      Flush does not affect PC; the mux already supplies the branch target.
//  - Misaligned is updated only when the PC updates: <= |NextPC[1:0]. It holds on stall.
//  - PCPlus4 = PC + 4, modulo 2^ADDR_W: 64'hFFFF_FFFF_FFFF_FFFC -> 0, with no carry out.
//  - IF/ID priority: reset > Flush > Stall > capture.
//      Flush: Valid=0, Inst=NOP_INST, IFID_PC=0.
//      Stall: all IF/ID fields hold.
//      Capture: IFID_PC=PC, IFID_Inst=InstIn, IFID_Valid=(state==RUN).
//  - Stall and Flush together: IF/ID is flushed and PC is held. The branch target is taken on the first non-stalled edge.
//  - Latency: PC to IF/ID is 1 cycle. Throughput is 1 instruction per cycle when Stall=0.
// CONFIGURATION
//  - Macro FETCH_PERF_CNT_EN.
//  - Defined: adds outputs StallCnt[31:0] and FlushCnt[31:0].
//      Both reset to 0.
//      +1 on each edge with Stall=1 (resp. Flush=1); both can increment on the same edge.
//      Saturate at 32'hFFFF_FFFF.
//  - Not defined: ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package/header (cpu_defs): ADDR_W, INST_W, NOP_INST, RESET_PC, FSM state encodings (BOOT=1'b0, RUN=1'b1).
//  - One sub-module: ifid_reg (the IF/ID register with flush/stall priority).
//  - PC register, adder, FSM and counters stay in pc_fetch_stage.
// TESTING
//  - Reset and boot:
//      reset=1 for 2 cycles, then 0; NextPC=PCPlus4, InstIn=32'h8B020020.
//      Expect PC=0 then 4; first captured IF/ID has Valid=0, Inst=D503201F; the next capture has Valid=1, IFID_PC=4.
//  - Sequential fetch: 3 cycles with S=0 (NextPC=PCPlus4) -> PC 4,8,12; IFID_PC trails by one cycle.
//  - Stall: Stall=1 for 2 cycles at PC=8 -> PC and all IF/ID outputs frozen; resume with PC=12 on release.
//  - Flush:
//      Flush=1 with NextPC=64'h40 -> PC=40, IF/ID Valid=0, Inst=NOP.
//      Same cycle with Stall=1 also -> PC holds, IF/ID still flushed.
//  - Wrap and alignment:
//      PC=64'hFFFF_FFFF_FFFF_FFFC -> PCPlus4=0.
//      NextPC=64'h46 -> PC=44, Misaligned=1.
//  - Perf counters (FETCH_PERF_CNT_EN defined): 3 stall edges + 1 flush edge -> StallCnt=3, FlushCnt=1; reset mid-run -> both 0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths, reset PC, NOP encoding, fetch FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_defs_pkg;

    localparam int          DEF_ADDR_W   = 64;
    localparam int          DEF_INST_W   = 32;
    localparam logic [63:0] DEF_RESET_PC = 64'h0;
    // ARMv8 NOP, injected into IF/ID whenever it must hold a bubble
    localparam logic [31:0] DEF_NOP_INST = 32'hD503201F;

    // BOOT lasts exactly one edge after reset release, then RUN forever
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage : cpu_defs_pkg

// File: rtl/pc_fetch_stage_ifid_reg.sv
// IF/ID pipeline register with flush-over-stall-over-capture priority.
// Latency: 1 cycle from capture inputs to outputs.
// Backpressure: stall holds every field; flush squashes to a NOP bubble even while stalled.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   flush, stall            squash / hold controls from branch and hazard logic
//   cap_pc, cap_inst,
//   cap_valid               fields loaded on a normal capture edge
//   ifid_pc, ifid_inst,
//   ifid_valid              registered IF/ID contents
module ifid_reg
    import cpu_defs_pkg::*;
#(
    parameter int               ADDR_W   = DEF_ADDR_W,
    parameter int               INST_W   = DEF_INST_W,
    parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST[INST_W-1:0]
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic [ADDR_W-1:0] cap_pc,
    input  logic [INST_W-1:0] cap_inst,
    input  logic              cap_valid,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [INST_W-1:0] ifid_inst,
    output logic              ifid_valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_pc    <= '0;
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end else if (flush) begin
            // A taken branch wins over a stall: the wrong-path instruction must die
            ifid_pc    <= '0;
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_pc    <= cap_pc;
            ifid_inst  <= cap_inst;
            ifid_valid <= cap_valid;
        end
    end

endmodule : ifid_reg

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, PC+4 adder, boot FSM and IF/ID register (optional perf counters).
// Latency: PC to IF/ID 1 cycle; PCPlus4 combinational; 1 instruction/cycle when not stalled.
// Backpressure: Stall holds PC, Misaligned and IF/ID; Flush squashes IF/ID but never moves PC.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset (overrides everything)
//   NextPC          next-PC mux output (PC+4 or branch target)
//   Stall, Flush    hazard-unit hold / branch squash
//   InstIn          instruction memory read data for address PC (combinational read)
//   PC              current PC, also the instruction memory address
//   PCPlus4         PC + 4 modulo 2^ADDR_W, back to the mux
//   IFID_PC, IFID_Inst, IFID_Valid   IF/ID register contents
//   Misaligned      NextPC[1:0] was non-zero when last accepted
//   StallCnt, FlushCnt   saturating event counters, only with FETCH_PERF_CNT_EN defined
//
// Build option: define FETCH_PERF_CNT_EN to add StallCnt/FlushCnt.
module pc_fetch_stage
    import cpu_defs_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC[ADDR_W-1:0],
    parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST[INST_W-1:0]
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] NextPC,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [INST_W-1:0] InstIn,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic [ADDR_W-1:0] IFID_PC,
    output logic [INST_W-1:0] IFID_Inst,
    output logic              IFID_Valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushCnt,
`endif
    output logic              Misaligned
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [ADDR_W-1:0] pc_q;
    logic              misaligned_q;

    logic [ADDR_W-1:0] cap_pc;
    logic [INST_W-1:0] cap_inst;
    logic              cap_valid;

    // ------------------------------------------------------------------
    // Boot FSM: the first edge after reset release always inserts a bubble,
    // because InstIn for RESET_PC is not trusted on that edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cap_pc    = pc_q;
        cap_inst  = InstIn;
        cap_valid = 1'b1;
        case (state_q)
            BOOT: begin
                state_d   = RUN;
                cap_pc    = '0;
                cap_inst  = NOP_INST;
                cap_valid = 1'b0;
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC register. The low two bits are forced to zero so the fetch address
    // is always word aligned; a non-zero request is reported via Misaligned.
    // Flush is deliberately ignored here: the mux already presents the target.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
        end else if (!Stall) begin
            pc_q         <= {NextPC[ADDR_W-1:2], 2'b00};
            misaligned_q <= |NextPC[1:0];
        end
    end

    assign PC         = pc_q;
    // Wraps silently at the top of the address space; carry is discarded
    assign PCPlus4    = pc_q + PC_STEP;
    assign Misaligned = misaligned_q;

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    ifid_reg #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP_INST)
    ) u_ifid_reg (
        .clk        (clk),
        .reset      (reset),
        .flush      (Flush),
        .stall      (Stall),
        .cap_pc     (cap_pc),
        .cap_inst   (cap_inst),
        .cap_valid  (cap_valid),
        .ifid_pc    (IFID_PC),
        .ifid_inst  (IFID_Inst),
        .ifid_valid (IFID_Valid)
    );

`ifdef FETCH_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters; stall and flush counted independently
    // so both may step on the same edge.
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (Flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule : pc_fetch_stage

// File: tb/tb_pc_fetch_stage.sv
// Directed, table-driven bench for pc_fetch_stage.
// Latency: each vector is applied for one clock edge and checked 1 ns after it.
// Backpressure: Stall/Flush driven directly from the vector table.
module tb_pc_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] NextPC;
    logic        Stall;
    logic        Flush;
    logic [31:0] InstIn;
    logic [63:0] PC;
    logic [63:0] PCPlus4;
    logic [63:0] IFID_PC;
    logic [31:0] IFID_Inst;
    logic        IFID_Valid;
    logic        Misaligned;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] StallCnt;
    logic [31:0] FlushCnt;
`endif

    always #5 clk = ~clk;

    pc_fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .NextPC     (NextPC),
        .Stall      (Stall),
        .Flush      (Flush),
        .InstIn     (InstIn),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .IFID_PC    (IFID_PC),
        .IFID_Inst  (IFID_Inst),
        .IFID_Valid (IFID_Valid),
`ifdef FETCH_PERF_CNT_EN
        .StallCnt   (StallCnt),
        .FlushCnt   (FlushCnt),
`endif
        .Misaligned (Misaligned)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [63:0] next_pc;
        logic [31:0] inst;
        logic [63:0] exp_pc;
        logic [63:0] exp_ifid_pc;
        logic [31:0] exp_inst;
        logic        exp_valid;
        logic        exp_mis;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stall, input logic flush,
                       input logic [63:0] next_pc, input logic [31:0] inst,
                       input logic [63:0] exp_pc, input logic [63:0] exp_ifid_pc,
                       input logic [31:0] exp_inst, input logic exp_valid,
                       input logic exp_mis);
        vec_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.next_pc = next_pc; v.inst = inst;
        v.exp_pc = exp_pc; v.exp_ifid_pc = exp_ifid_pc; v.exp_inst = exp_inst;
        v.exp_valid = exp_valid; v.exp_mis = exp_mis;
        vecs.push_back(v);
    endtask

    initial begin
        logic [63:0] mpc;
        logic [63:0] mifid;
        int          scnt;
        int          fcnt;

        reset  = 1'b1;
        Stall  = 1'b0;
        Flush  = 1'b0;
        NextPC = 64'h0;
        InstIn = 32'h0;

        //   rst stl fls next_pc                 inst          exp_pc                  exp_ifid_pc             exp_inst      v  mis
        add(1, 0, 0, 64'h0,                  32'h8B020020, 64'h0,                  64'h0,                  NOP,          0, 0); // reset
        add(1, 0, 0, 64'h0,                  32'h8B020020, 64'h0,                  64'h0,                  NOP,          0, 0); // reset
        add(0, 0, 0, 64'h4,                  32'h8B020020, 64'h4,                  64'h0,                  NOP,          0, 0); // boot bubble
        add(0, 0, 0, 64'h8,                  32'h8B020021, 64'h8,                  64'h4,                  32'h8B020021, 1, 0); // first real capture
        add(0, 1, 0, 64'hC,                  32'h8B020022, 64'h8,                  64'h4,                  32'h8B020021, 1, 0); // stall
        add(0, 1, 0, 64'hC,                  32'h8B020022, 64'h8,                  64'h4,                  32'h8B020021, 1, 0); // stall
        add(0, 0, 0, 64'hC,                  32'h8B020022, 64'hC,                  64'h8,                  32'h8B020022, 1, 0); // resume
        add(0, 0, 0, 64'h10,                 32'h8B020023, 64'h10,                 64'hC,                  32'h8B020023, 1, 0);
        add(0, 0, 1, 64'h40,                 32'h8B020024, 64'h40,                 64'h0,                  NOP,          0, 0); // flush to 0x40
        add(0, 0, 0, 64'h44,                 32'h8B020025, 64'h44,                 64'h40,                 32'h8B020025, 1, 0);
        add(0, 1, 1, 64'h80,                 32'h8B020026, 64'h44,                 64'h0,                  NOP,          0, 0); // stall+flush
        add(0, 0, 0, 64'h80,                 32'h8B020025, 64'h80,                 64'h44,                 32'h8B020025, 1, 0); // target taken
        add(0, 0, 0, 64'h46,                 32'h8B020027, 64'h44,                 64'h80,                 32'h8B020027, 1, 1); // misaligned
        add(0, 1, 0, 64'h48,                 32'h8B020028, 64'h44,                 64'h80,                 32'h8B020027, 1, 1); // mis holds on stall
        add(0, 0, 0, 64'h48,                 32'h8B020029, 64'h48,                 64'h44,                 32'h8B020029, 1, 0);
        add(0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h8B02002A, 64'hFFFF_FFFF_FFFF_FFFC, 64'h48,                 32'h8B02002A, 1, 0);
        add(0, 0, 0, 64'h0,                  32'h8B02002B, 64'h0,                  64'hFFFF_FFFF_FFFF_FFFC, 32'h8B02002B, 1, 0); // wrap
        add(1, 1, 1, 64'h80,                 32'h8B02002C, 64'h0,                  64'h0,                  NOP,          0, 0); // reset wins
        add(0, 0, 0, 64'h4,                  32'h8B02002D, 64'h4,                  64'h0,                  NOP,          0, 0); // boot bubble again
        add(0, 0, 0, 64'h9,                  32'h8B02002E, 64'h8,                  64'h4,                  32'h8B02002E, 1, 1);
        add(1, 1, 0, 64'hC,                  32'h8B02002F, 64'h0,                  64'h0,                  NOP,          0, 0); // reset mid-stall
        add(0, 0, 0, 64'h4,                  32'h8B020030, 64'h4,                  64'h0,                  NOP,          0, 0);

        scnt = 0;
        fcnt = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            reset  = vecs[i].rst;
            Stall  = vecs[i].stall;
            Flush  = vecs[i].flush;
            NextPC = vecs[i].next_pc;
            InstIn = vecs[i].inst;
            @(posedge clk);
            #1;
            if (vecs[i].rst) begin
                scnt = 0;
                fcnt = 0;
            end else begin
                if (vecs[i].stall) scnt++;
                if (vecs[i].flush) fcnt++;
            end
            check("pc",         i, PC,                 vecs[i].exp_pc);
            check("pcplus4",    i, PCPlus4,            vecs[i].exp_pc + 64'd4);
            check("ifid_pc",    i, IFID_PC,            vecs[i].exp_ifid_pc);
            check("ifid_inst",  i, 64'(IFID_Inst),     64'(vecs[i].exp_inst));
            check("ifid_valid", i, 64'(IFID_Valid),    64'(vecs[i].exp_valid));
            check("misaligned", i, 64'(Misaligned),    64'(vecs[i].exp_mis));
`ifdef FETCH_PERF_CNT_EN
            check("stall_cnt",  i, 64'(StallCnt),      64'(scnt));
            check("flush_cnt",  i, 64'(FlushCnt),      64'(fcnt));
`endif
        end

        // Hand-written run: straight-line fetch continuing from PC=4 (in RUN),
        // IF/ID must trail PC by exactly one edge.
        mpc   = 64'h4;
        mifid = 64'h0;
        for (int k = 0; k < 6; k++) begin
            Stall  = 1'b0;
            Flush  = 1'b0;
            NextPC = mpc + 64'd4;
            InstIn = 32'hA000_0000 | 32'(k);
            @(posedge clk);
            #1;
            mifid = mpc;
            mpc   = mpc + 64'd4;
            check("seq_pc",    100 + k, PC,             mpc);
            check("seq_ifid",  100 + k, IFID_PC,        mifid);
            check("seq_inst",  100 + k, 64'(IFID_Inst), 64'(32'hA000_0000 | 32'(k)));
            check("seq_valid", 100 + k, 64'(IFID_Valid), 64'd1);
        end

        // Hand-written: a long stall keeps everything frozen, then one edge releases it.
        Stall  = 1'b1;
        NextPC = 64'h200;
        InstIn = 32'hBBBB_BBBB;
        repeat (4) @(posedge clk);
        #1;
        check("hold_pc",    200, PC,             mpc);
        check("hold_ifid",  200, IFID_PC,        mifid);
        check("hold_inst",  200, 64'(IFID_Inst), 64'(32'hA000_0005));
        Stall = 1'b0;
        @(posedge clk);
        #1;
        check("rel_pc",     201, PC,             64'h200);
        check("rel_ifid",   201, IFID_PC,        mpc);
        check("rel_inst",   201, 64'(IFID_Inst), 64'(32'hBBBB_BBBB));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_fetch_stage
